core_fetch_pc_gen: RTL and testbench

CORE_FETCH_PC_GEN -- requirements
Module: core_fetch_pc_gen

---
 rtl/core_fetch_pc_gen.sv | 101 ++++++++++
 tb/tb_core_fetch_pc_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch_pc_gen.sv
// Fetch PC generator: produces the fetch-group address and lane mask each cycle,
// arbitrating backend and predictor redirects and parking a backend redirect while fetch cannot advance.
module core_fetch_pc_gen #(
    parameter logic [31:0] RESET_PC    = 32'h1c00_0000,
    parameter int          FETCH_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   f_stall_i,
    input  logic                   ready_i,
    input  logic                   be_redirect_i,
    input  logic [31:0]            be_target_i,
    input  logic                   bpu_redirect_i,
    input  logic [31:0]            bpu_target_i,
    output logic                   valid_o,
    output logic [31:0]            vaddr_o,
    output logic [FETCH_WIDTH-1:0] mask_o
);

    localparam logic [31:0] GROUP_BYTES = 32'(FETCH_WIDTH * 4);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_PEND
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_pend;
    logic [31:0] w_pend_next;
    logic [31:0] w_seq_pc;
    logic        w_advance;

    assign valid_o   = (r_state != ST_BOOT);
    assign vaddr_o   = r_pc;
    assign w_advance = valid_o && ready_i && !f_stall_i;
    // Align down to the group boundary before stepping, so unaligned targets rejoin the grid.
    assign w_seq_pc  = (r_pc & ~(GROUP_BYTES - 32'd1)) + GROUP_BYTES;

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_pend_next  = r_pend;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_advance) begin
                    if (be_redirect_i)       w_pc_next = be_target_i;
                    else if (bpu_redirect_i) w_pc_next = bpu_target_i;
                    else                     w_pc_next = w_seq_pc;
                end else if (be_redirect_i) begin
                    w_pend_next  = be_target_i;
                    w_state_next = ST_PEND;
                end
            end
            ST_PEND: begin
                // The predictor is ignored here: its redirect belongs to a group that is being flushed.
                if (w_advance) begin
                    w_pc_next    = be_redirect_i ? be_target_i : r_pend;
                    w_state_next = ST_RUN;
                end else if (be_redirect_i) begin
                    w_pend_next = be_target_i;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_pend  <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_pend  <= w_pend_next;
        end
    end

    generate
        if (FETCH_WIDTH == 1) begin : g_mask_single
            assign mask_o = 1'b1;
        end else begin : g_mask_multi
            localparam int IDX_W = $clog2(FETCH_WIDTH);
            logic [IDX_W-1:0] w_lane_off;
            assign w_lane_off = r_pc[IDX_W+1:2];
            for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
                assign mask_o[gi] = (IDX_W'(gi) >= w_lane_off);
            end
        end
    endgenerate

endmodule

// File: tb/tb_core_fetch_pc_gen.sv
// Self-checking bench for core_fetch_pc_gen: directed redirect/stall/reset scenarios
// followed by randomized traffic, all compared cycle by cycle against a behavioural model.
module tb_core_fetch_pc_gen;

    localparam logic [31:0] RESET_PC    = 32'h1c00_0000;
    localparam int          FETCH_WIDTH = 2;
    localparam int          G           = FETCH_WIDTH * 4;

    logic                   clk;
    logic                   rst_n;
    logic                   f_stall_i;
    logic                   ready_i;
    logic                   be_redirect_i;
    logic [31:0]            be_target_i;
    logic                   bpu_redirect_i;
    logic [31:0]            bpu_target_i;
    logic                   valid_o;
    logic [31:0]            vaddr_o;
    logic [FETCH_WIDTH-1:0] mask_o;

    int n_tests;
    int n_fail;

    // Behavioural model: "has fetched since reset", current PC, and an optional parked backend target.
    bit          m_started;
    logic [31:0] m_pc;
    bit          m_has_pend;
    logic [31:0] m_pend;

    core_fetch_pc_gen #(
        .RESET_PC   (RESET_PC),
        .FETCH_WIDTH(FETCH_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .f_stall_i     (f_stall_i),
        .ready_i       (ready_i),
        .be_redirect_i (be_redirect_i),
        .be_target_i   (be_target_i),
        .bpu_redirect_i(bpu_redirect_i),
        .bpu_target_i  (bpu_target_i),
        .valid_o       (valid_o),
        .vaddr_o       (vaddr_o),
        .mask_o        (mask_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [FETCH_WIDTH-1:0] model_mask(input logic [31:0] pc);
        logic [FETCH_WIDTH-1:0] m;
        int lane;
        lane = int'((pc % G) / 4);
        for (int i = 0; i < FETCH_WIDTH; i++) m[i] = (i >= lane);
        return m;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(valid_o), 32'(m_started));
        check({tag, ".vaddr"}, vaddr_o, m_pc);
        check({tag, ".mask"},  32'(mask_o), 32'(model_mask(m_pc)));
    endtask

    task automatic model_reset();
        m_started  = 1'b0;
        m_pc       = RESET_PC;
        m_has_pend = 1'b0;
        m_pend     = 32'd0;
    endtask

    // One clock: drive inputs (called just after a falling edge), update model at the rising edge,
    // compare on the following falling edge.
    task automatic cycle(input string tag, input bit stall, input bit rdy,
                         input bit be, input logic [31:0] bt,
                         input bit bpu, input logic [31:0] pt);
        bit adv;
        f_stall_i      = stall;
        ready_i        = rdy;
        be_redirect_i  = be;
        be_target_i    = bt;
        bpu_redirect_i = bpu;
        bpu_target_i   = pt;
        adv = m_started && rdy && !stall;
        @(posedge clk);
        if (!m_started) begin
            m_started = 1'b1;
        end else if (adv) begin
            if (be)              m_pc = bt;
            else if (m_has_pend) m_pc = m_pend;
            else if (bpu)        m_pc = pt;
            else                 m_pc = (m_pc - (m_pc % G)) + G;
            m_has_pend = 1'b0;
        end else if (be) begin
            m_has_pend = 1'b1;
            m_pend     = bt;
        end
        @(negedge clk);
        $display("[TB] %-10s stall=%0b rdy=%0b be=%0b bt=%h bpu=%0b pt=%h -> valid=%0b vaddr=%h mask=%b",
                 tag, stall, rdy, be, bt, bpu, pt, valid_o, vaddr_o, mask_o);
        check_outputs(tag);
    endtask

    task automatic adv_cycle(input string tag);
        cycle(tag, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    // Reset asserted mid-cycle; outputs must change without waiting for a clock edge.
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst_valid"}, 32'(valid_o), 32'd0);
        check({tag, ".rst_vaddr"}, vaddr_o, RESET_PC);
        @(negedge clk);
        check_outputs({tag, ".held"});
        rst_n = 1'b1;
    endtask

    logic [31:0] tgt_pool [8];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n          = 1'b0;
        f_stall_i      = 1'b0;
        ready_i        = 1'b0;
        be_redirect_i  = 1'b0;
        be_target_i    = 32'd0;
        bpu_redirect_i = 1'b0;
        bpu_target_i   = 32'd0;
        model_reset();
        tgt_pool = '{32'h1c00_0040, 32'h1c00_0104, 32'hffff_fff8, 32'hffff_fffc,
                     32'h0000_0002, 32'h1c00_0500, 32'h8000_0004, 32'h1c00_0080};

        repeat (2) @(negedge clk);
        check("boot.valid", 32'(valid_o), 32'd0);
        check("boot.mask", 32'(mask_o), 32'b11);
        rst_n = 1'b1;

        // Boot and sequential stepping.
        adv_cycle("boot");
        check("seq0", vaddr_o, 32'h1c00_0000);
        adv_cycle("seq1");
        check("seq1", vaddr_o, 32'h1c00_0008);
        adv_cycle("seq2");
        check("seq2", vaddr_o, 32'h1c00_0010);

        // Unaligned backend redirect, then realignment.
        cycle("be_redir", 0, 1, 1, 32'h1c00_0104, 0, 0);
        check("redir_addr", vaddr_o, 32'h1c00_0104);
        check("redir_mask", 32'(mask_o), 32'b10);
        adv_cycle("realign");
        check("realign", vaddr_o, 32'h1c00_0108);

        // Backend redirects during a stall: last one wins, applied after release.
        cycle("stall1", 1, 1, 1, 32'h1c00_0200, 0, 0);
        check("stall1_hold", vaddr_o, 32'h1c00_0108);
        cycle("stall2", 1, 1, 1, 32'h1c00_0300, 1, 32'h1c00_0700);
        cycle("stall3", 1, 1, 0, 0, 0, 0);
        check("stall3_hold", vaddr_o, 32'h1c00_0108);
        adv_cycle("release");
        check("pend_apply", vaddr_o, 32'h1c00_0300);

        // Backend beats predictor; predictor ignored while not ready.
        cycle("both", 0, 1, 1, 32'h1c00_0040, 1, 32'h1c00_0080);
        check("be_prio", vaddr_o, 32'h1c00_0040);
        cycle("bpu_nrdy", 0, 0, 0, 0, 1, 32'h1c00_0080);
        check("bpu_ignored", vaddr_o, 32'h1c00_0040);
        cycle("bpu_take", 0, 1, 0, 0, 1, 32'h1c00_0080);
        check("bpu_taken", vaddr_o, 32'h1c00_0080);

        // Reset while a redirect is parked discards it.
        cycle("park", 1, 1, 1, 32'h1c00_0500, 0, 0);
        async_reset("rst_pend");
        adv_cycle("rboot");
        check("rst_first", vaddr_o, 32'h1c00_0000);
        adv_cycle("rseq");
        check("rst_no_pend", vaddr_o, 32'h1c00_0008);

        // Address wrap at the top of the space.
        cycle("to_top", 0, 1, 1, 32'hffff_fff8, 0, 0);
        check("top_mask", 32'(mask_o), 32'b11);
        adv_cycle("wrap");
        check("wrap_addr", vaddr_o, 32'h0000_0000);
        check("wrap_mask", 32'(mask_o), 32'b11);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] bt;
            logic [31:0] pt;
            if ($urandom_range(99) == 0) begin
                async_reset("rnd_rst");
            end
            bt = ($urandom_range(1) == 0) ? tgt_pool[$urandom_range(7)] : $urandom;
            pt = ($urandom_range(1) == 0) ? tgt_pool[$urandom_range(7)] : $urandom;
            cycle("rnd", ($urandom_range(3) == 0), ($urandom_range(3) != 0),
                  ($urandom_range(4) == 0), bt, ($urandom_range(3) == 0), pt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
